mem_rmw_bridge: RTL and testbench
=================================

MEM_RMW_BRIDGE -- requirements
Module: mem_rmw_bridge

Interface
REQ-001 ADDR_WIDTH, 32, byte-address width on both ports.
REQ-002 USER_WIDTH, 32, sideband tag width; data width is fixed at 32.
REQ-003 mem_clk  in  1  single clock; all state updates on the rising edge.
REQ-004 mem_reset  in  1  asynchronous, active-high reset.
REQ-005 cpu_valid_i  in  1  request strobe.
REQ-006 cpu_read_i  in  1  read request.
REQ-007 cpu_write_i  in  1  write request.
REQ-008 cpu_size_i  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 cpu_signed_i  in  1  sign-extend sub-word read data.
REQ-010 cpu_addr_i  in  ADDR_WIDTH  byte address.
REQ-011 cpu_data_i  in  32  write data, right-justified.
REQ-012 cpu_user_i  in  USER_WIDTH  tag returned with the response.
REQ-013 cpu_ready_o  out  1  bridge can accept a request this cycle.
REQ-014 cpu_valid_o  out  1  one-cycle response strobe.
REQ-015 cpu_error_o  out  1  response is an error; qualified by cpu_valid_o.
REQ-016 cpu_data_o  out  32  read data, lane-extracted and extended; 0 for writes and errors.
REQ-017 cpu_user_o  out  USER_WIDTH  tag of the completing request.
REQ-018 mem_valid_o, mem_read_o, mem_write_o  out  1 each  word-memory request strobes, registered.
REQ-019 mem_addr_o  out  ADDR_WIDTH  word-aligned address, bits [1:0] always 0.
REQ-020 mem_data_o  out  32  word write data.
REQ-021 mem_user_o  out  USER_WIDTH  copy of the latched cpu_user_i.
REQ-022 mem_valid_i  in  1  memory response, expected exactly 2 edges after issue.
REQ-023 mem_data_i  in  32  memory read word.

Function
REQ-024 States SHALL be IDLE, RD_WAIT, RMW_RD_WAIT, RMW_WR_WAIT and RESP; cpu_ready_o SHALL be 1 only in IDLE.
REQ-025 At an accept edge E0 (cpu_valid_i && cpu_ready_o), the bridge SHALL latch addr, size, signed, data and user; a valid request with neither read nor write SHALL be ignored.
REQ-026 Read (any size) or word write: mem_valid_o SHALL be high for exactly one cycle after E0; state moves to RD_WAIT or RMW_WR_WAIT.
REQ-027 Sub-word write: the bridge SHALL first issue a word read (RMW_RD_WAIT), then on the edge sampling mem_valid_i issue a write with the merged word; cpu_valid_o SHALL rise on edge E0+4.
REQ-028 Merge: byte lane = addr[1:0], halfword lane = addr[1]; only the addressed lane SHALL be replaced and all other bytes SHALL come from mem_data_i.
REQ-029 Read or word write: cpu_valid_o SHALL rise on edge E0+2 and stay high for exactly one cycle; the state returns to IDLE.
REQ-030 Read extraction: the selected byte or halfword SHALL be zero-extended, or sign-extended when the latched signed bit = 1; word reads SHALL pass unchanged.
REQ-031 Memory timeout: if mem_valid_i = 0 on the expected sampling edge, the bridge SHALL respond with error and cpu_data_o = 0, and a pending RMW write SHALL NOT be issued.
REQ-032 The following requests SHALL produce an error response on edge E0+1 with no memory access: both read and write set, or size 11.
REQ-033 mem_valid_i arriving while in IDLE SHALL be ignored.

Reset
REQ-034 Asserting mem_reset at any time SHALL force IDLE and drive every output to 0 except cpu_ready_o; the in-flight transaction SHALL be dropped with no response.
REQ-035 After mem_reset deasserts, cpu_ready_o SHALL be 1 from the first clock edge onward.

Configuration
REQ-036 With MEM_RMW_BRIDGE_ALIGN_CHECK_EN defined, a halfword with addr[0] = 1 or a word with addr[1:0] != 0 SHALL be an immediate error (REQ-032 timing).
REQ-037 Without MEM_RMW_BRIDGE_ALIGN_CHECK_EN, misaligned low address bits SHALL be silently truncated to the size's natural alignment.

Verification
REQ-038 Memory word 0x4000_0000 = 0x11223344; byte read at 0x4000_0002 with signed = 0 -> cpu_valid_o rises on E0+2, data 0x00000022, error 0.
REQ-039 Memory word 0x4000_0004 = 0x0000_8000; halfword signed read at 0x4000_0004 -> data 0xFFFF8000.
REQ-040 Memory word 0x4000_0000 = 0x11223344; byte write 0xAB at 0x4000_0001 -> read then write issued, response on E0+4, memory word becomes 0x1122AB44.
REQ-041 Word read at 0x3FFF_FFF0, outside the memory so no mem_valid_i -> error on E0+2, data 0; size 11 request -> error on E0+1 and mem_valid_o never set.
REQ-042 Assert mem_reset during RMW_RD_WAIT -> outputs go to 0 asynchronously, no write is issued, no response, and cpu_ready_o = 1 after release.
REQ-043 Halfword read at 0x4000_0001 -> error on E0+1 with the macro defined; without it, the bridge returns the halfword at 0x4000_0000.

Source files
------------

// File: rtl/mem_rmw_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_rmw_bridge: sub-word CPU port to 32-bit word memory, read-mod-write. |
// | Option: MEM_RMW_BRIDGE_ALIGN_CHECK_EN flags misaligned half/word access. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_rmw_bridge #(
   parameter int ADDR_WIDTH = 32,
   parameter int USER_WIDTH = 32
) (
   input  logic                  mem_clk,
   input  logic                  mem_reset,
   input  logic                  cpu_valid_i,
   input  logic                  cpu_read_i,
   input  logic                  cpu_write_i,
   input  logic [1:0]            cpu_size_i,
   input  logic                  cpu_signed_i,
   input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
   input  logic [31:0]           cpu_data_i,
   input  logic [USER_WIDTH-1:0] cpu_user_i,
   output logic                  cpu_ready_o,
   output logic                  cpu_valid_o,
   output logic                  cpu_error_o,
   output logic [31:0]           cpu_data_o,
   output logic [USER_WIDTH-1:0] cpu_user_o,
   output logic                  mem_valid_o,
   output logic                  mem_read_o,
   output logic                  mem_write_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [31:0]           mem_data_o,
   output logic [USER_WIDTH-1:0] mem_user_o,
   input  logic                  mem_valid_i,
   input  logic [31:0]           mem_data_i
);

   localparam logic [2:0] S_IDLE        = 3'd0;
   localparam logic [2:0] S_RD_WAIT     = 3'd1;
   localparam logic [2:0] S_RMW_RD_WAIT = 3'd2;
   localparam logic [2:0] S_RMW_WR_WAIT = 3'd3;
   localparam logic [2:0] S_RESP        = 3'd4;

   localparam logic [1:0] c_SZ_BYTE = 2'b00;
   localparam logic [1:0] c_SZ_HALF = 2'b01;
   localparam logic [1:0] c_SZ_WORD = 2'b10;
   localparam logic [1:0] c_SZ_ILL  = 2'b11;

   logic [2:0]            state_q, state_d;
   logic                  cnt_q, cnt_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [1:0]            size_q, size_d;
   logic                  signed_q, signed_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [USER_WIDTH-1:0] user_q, user_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  mem_valid_q, mem_valid_d;
   logic                  mem_read_q, mem_read_d;
   logic                  mem_write_q, mem_write_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]           mem_data_q, mem_data_d;
   logic [USER_WIDTH-1:0] mem_user_q, mem_user_d;

   logic                  w_accept;
   logic                  w_illegal;
   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [31:0]           w_rd_ext;
   logic [31:0]           w_merged;

   assign w_accept = (state_q == S_IDLE) && cpu_valid_i && (cpu_read_i || cpu_write_i);

`ifdef MEM_RMW_BRIDGE_ALIGN_CHECK_EN
   assign w_illegal = (cpu_read_i && cpu_write_i) || (cpu_size_i == c_SZ_ILL) ||
                      ((cpu_size_i == c_SZ_HALF) && cpu_addr_i[0]) ||
                      ((cpu_size_i == c_SZ_WORD) && (cpu_addr_i[1:0] != 2'b00));
`else
   assign w_illegal = (cpu_read_i && cpu_write_i) || (cpu_size_i == c_SZ_ILL);
`endif

   // Lane select uses the latched address; unused low bits are ignored per size.
   always_comb begin
      w_byte = 8'h00;
      case (addr_q[1:0])
         2'd0:    w_byte = mem_data_i[7:0];
         2'd1:    w_byte = mem_data_i[15:8];
         2'd2:    w_byte = mem_data_i[23:16];
         default: w_byte = mem_data_i[31:24];
      endcase
      w_half = addr_q[1] ? mem_data_i[31:16] : mem_data_i[15:0];
      case (size_q)
         c_SZ_BYTE: w_rd_ext = {{24{signed_q & w_byte[7]}}, w_byte};
         c_SZ_HALF: w_rd_ext = {{16{signed_q & w_half[15]}}, w_half};
         default:   w_rd_ext = mem_data_i;
      endcase
   end

   always_comb begin
      w_merged = mem_data_i;
      if (size_q == c_SZ_BYTE) begin
         case (addr_q[1:0])
            2'd0:    w_merged[7:0]   = wdata_q[7:0];
            2'd1:    w_merged[15:8]  = wdata_q[7:0];
            2'd2:    w_merged[23:16] = wdata_q[7:0];
            default: w_merged[31:24] = wdata_q[7:0];
         endcase
      end else if (addr_q[1]) begin
         w_merged[31:16] = wdata_q[15:0];
      end else begin
         w_merged[15:0]  = wdata_q[15:0];
      end
   end

   always_ff @(posedge mem_clk or posedge mem_reset) begin
      if (mem_reset) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               if (w_illegal || cpu_read_i)       state_d = S_RD_WAIT;
               else if (cpu_size_i == c_SZ_WORD)  state_d = S_RMW_WR_WAIT;
               else                               state_d = S_RMW_RD_WAIT;
            end
         end
         S_RD_WAIT:     if (!cnt_q) state_d = S_RESP;
         S_RMW_RD_WAIT: if (!cnt_q) state_d = mem_valid_i ? S_RMW_WR_WAIT : S_RESP;
         S_RMW_WR_WAIT: if (!cnt_q) state_d = S_RESP;
         S_RESP:        state_d = S_IDLE;
         default:       state_d = S_IDLE;
      endcase
   end

   always_comb begin
      cpu_ready_o = (state_q == S_IDLE);
      cpu_valid_o = (state_q == S_RESP);
      cpu_error_o = (state_q == S_RESP) && err_q;
      cpu_data_o  = (state_q == S_RESP) ? rdata_q : 32'h0;
      cpu_user_o  = (state_q == S_RESP) ? user_q : '0;
      mem_valid_o = mem_valid_q;
      mem_read_o  = mem_read_q;
      mem_write_o = mem_write_q;
      mem_addr_o  = mem_addr_q;
      mem_data_o  = mem_data_q;
      mem_user_o  = mem_user_q;
   end

   // Illegal requests park one cycle in RD_WAIT (cnt=0) so the error lands on E0+1.
   always_comb begin
      cnt_d       = 1'b0;
      err_d       = err_q;
      addr_d      = addr_q;
      size_d      = size_q;
      signed_d    = signed_q;
      wdata_d     = wdata_q;
      user_d      = user_q;
      rdata_d     = rdata_q;
      mem_valid_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_data_d  = mem_data_q;
      mem_user_d  = mem_user_q;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               addr_d   = cpu_addr_i;
               size_d   = cpu_size_i;
               signed_d = cpu_signed_i;
               wdata_d  = cpu_data_i;
               user_d   = cpu_user_i;
               rdata_d  = 32'h0;
               err_d    = w_illegal;
               if (!w_illegal) begin
                  cnt_d       = 1'b1;
                  mem_valid_d = 1'b1;
                  mem_read_d  = cpu_read_i || (cpu_size_i != c_SZ_WORD);
                  mem_write_d = cpu_write_i && (cpu_size_i == c_SZ_WORD);
                  mem_addr_d  = {cpu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                  mem_user_d  = cpu_user_i;
                  if (cpu_write_i && (cpu_size_i == c_SZ_WORD)) mem_data_d = cpu_data_i;
               end
            end
         end
         S_RD_WAIT: begin
            if (!cnt_q && !err_q) begin
               if (mem_valid_i) rdata_d = w_rd_ext;
               else             err_d   = 1'b1;
            end
         end
         S_RMW_RD_WAIT: begin
            if (!cnt_q) begin
               if (mem_valid_i) begin
                  cnt_d       = 1'b1;
                  mem_valid_d = 1'b1;
                  mem_write_d = 1'b1;
                  mem_data_d  = w_merged;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_RMW_WR_WAIT: begin
            if (!cnt_q && !mem_valid_i) err_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge mem_clk or posedge mem_reset) begin
      if (mem_reset) begin
         cnt_q       <= 1'b0;
         err_q       <= 1'b0;
         addr_q      <= '0;
         size_q      <= 2'b00;
         signed_q    <= 1'b0;
         wdata_q     <= 32'h0;
         user_q      <= '0;
         rdata_q     <= 32'h0;
         mem_valid_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_data_q  <= 32'h0;
         mem_user_q  <= '0;
      end else begin
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         signed_q    <= signed_d;
         wdata_q     <= wdata_d;
         user_q      <= user_d;
         rdata_q     <= rdata_d;
         mem_valid_q <= mem_valid_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_data_q  <= mem_data_d;
         mem_user_q  <= mem_user_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_rmw_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_rmw_bridge: directed self-checking bench with a 2-cycle word RAM. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_rmw_bridge;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cpu_valid_i = 1'b0, cpu_read_i = 1'b0, cpu_write_i = 1'b0, cpu_signed_i = 1'b0;
   logic [1:0]  cpu_size_i = 2'b00;
   logic [31:0] cpu_addr_i = '0, cpu_data_i = '0, cpu_user_i = '0;
   logic        cpu_ready_o, cpu_valid_o, cpu_error_o;
   logic [31:0] cpu_data_o, cpu_user_o;
   logic        mem_valid_o, mem_read_o, mem_write_o;
   logic [31:0] mem_addr_o, mem_data_o, mem_user_o;
   logic        mem_valid_i = 1'b0;
   logic [31:0] mem_data_i = '0;

   int checks = 0;
   int errors = 0;
   int rd_cnt = 0;
   int wr_cnt = 0;
   logic [31:0] last_addr = '0;
   logic [31:0] mem [16];

   always #5 clk = ~clk;

   mem_rmw_bridge #(.ADDR_WIDTH(32), .USER_WIDTH(32)) dut (
      .mem_clk(clk), .mem_reset(rst),
      .cpu_valid_i(cpu_valid_i), .cpu_read_i(cpu_read_i), .cpu_write_i(cpu_write_i),
      .cpu_size_i(cpu_size_i), .cpu_signed_i(cpu_signed_i), .cpu_addr_i(cpu_addr_i),
      .cpu_data_i(cpu_data_i), .cpu_user_i(cpu_user_i),
      .cpu_ready_o(cpu_ready_o), .cpu_valid_o(cpu_valid_o), .cpu_error_o(cpu_error_o),
      .cpu_data_o(cpu_data_o), .cpu_user_o(cpu_user_o),
      .mem_valid_o(mem_valid_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_user_o(mem_user_o),
      .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i)
   );

   // Word RAM at 0x4000_0000..0x4000_003F; responds exactly two edges after issue.
   initial begin
      logic        pend_v;
      logic [31:0] pend_d;
      pend_v = 1'b0;
      pend_d = '0;
      for (int i = 0; i < 16; i++) mem[i] = 32'h0;
      mem[0] = 32'h1122_3344;
      mem[1] = 32'h0000_8000;
      forever begin
         @(negedge clk);
         mem_valid_i = pend_v;
         mem_data_i  = pend_d;
         if (mem_valid_o) begin
            last_addr = mem_addr_o;
            if (mem_read_o)  rd_cnt++;
            if (mem_write_o) wr_cnt++;
            pend_v = (mem_addr_o[31:6] == 26'h100_0000);
            if (pend_v && mem_write_o) mem[mem_addr_o[5:2]] = mem_data_o;
            pend_d = pend_v ? mem[mem_addr_o[5:2]] : 32'h0;
         end else begin
            pend_v = 1'b0;
            pend_d = 32'h0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] d, input logic [31:0] u,
                         output int lat, output logic err, output logic [31:0] dat,
                         output logic [31:0] usr, output logic one_cyc);
      @(negedge clk);
      cpu_valid_i = 1'b1; cpu_read_i = rd; cpu_write_i = wr; cpu_size_i = sz;
      cpu_signed_i = sg; cpu_addr_i = a; cpu_data_i = d; cpu_user_i = u;
      @(posedge clk);
      #1;
      cpu_valid_i = 1'b0; cpu_read_i = 1'b0; cpu_write_i = 1'b0;
      lat = 0; err = 1'b0; dat = '0; usr = '0; one_cyc = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (cpu_valid_o) begin
            lat = k; err = cpu_error_o; dat = cpu_data_o; usr = cpu_user_o;
            @(posedge clk);
            #1;
            one_cyc = !cpu_valid_o && cpu_ready_o;
            break;
         end
      end
   endtask

   initial begin
      int          lat;
      logic        err, one;
      logic [31:0] dat, usr;
      int          rd0, wr0, seen;

      #2;
      check("rst_ready", 32'(cpu_ready_o), 32'd1);
      check("rst_valid", 32'(cpu_valid_o), 32'd0);
      check("rst_memv",  32'(mem_valid_o), 32'd0);
      check("rst_maddr", mem_addr_o, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_ready", 32'(cpu_ready_o), 32'd1);

      do_req(1, 0, 2'b00, 0, 32'h4000_0002, 0, 32'hA5A5_0001, lat, err, dat, usr, one);
      check("rdb_lat", 32'(lat), 32'd2);
      check("rdb_err", 32'(err), 32'd0);
      check("rdb_data", dat, 32'h0000_0022);
      check("rdb_user", usr, 32'hA5A5_0001);
      check("rdb_onecyc", 32'(one), 32'd1);
      check("rdb_maddr", last_addr, 32'h4000_0000);

      do_req(1, 0, 2'b01, 1, 32'h4000_0004, 0, 32'h2, lat, err, dat, usr, one);
      check("rdhs_data", dat, 32'hFFFF_8000);
      do_req(1, 0, 2'b00, 1, 32'h4000_0005, 0, 32'h3, lat, err, dat, usr, one);
      check("rdbs_neg", dat, 32'hFFFF_FF80);
      do_req(1, 0, 2'b00, 1, 32'h4000_0003, 0, 32'h4, lat, err, dat, usr, one);
      check("rdbs_pos", dat, 32'h0000_0011);
      do_req(1, 0, 2'b01, 0, 32'h4000_0004, 0, 32'h5, lat, err, dat, usr, one);
      check("rdhu_data", dat, 32'h0000_8000);
      do_req(1, 0, 2'b10, 0, 32'h4000_0000, 0, 32'h6, lat, err, dat, usr, one);
      check("rdw_data", dat, 32'h1122_3344);

      rd0 = rd_cnt; wr0 = wr_cnt;
      do_req(0, 1, 2'b00, 0, 32'h4000_0001, 32'hFFFF_FFAB, 32'h7, lat, err, dat, usr, one);
      check("wrb_lat", 32'(lat), 32'd4);
      check("wrb_err", 32'(err), 32'd0);
      check("wrb_data", dat, 32'h0);
      check("wrb_onecyc", 32'(one), 32'd1);
      check("wrb_rds", 32'(rd_cnt - rd0), 32'd1);
      check("wrb_wrs", 32'(wr_cnt - wr0), 32'd1);
      check("wrb_mem", mem[0], 32'h1122_AB44);

      do_req(0, 1, 2'b01, 0, 32'h4000_0002, 32'h1234_BEEF, 32'h8, lat, err, dat, usr, one);
      check("wrh_lat", 32'(lat), 32'd4);
      do_req(1, 0, 2'b10, 0, 32'h4000_0000, 0, 32'h9, lat, err, dat, usr, one);
      check("wrh_readback", dat, 32'hBEEF_AB44);

      rd0 = rd_cnt;
      do_req(0, 1, 2'b10, 0, 32'h4000_0008, 32'hCAFE_F00D, 32'hA, lat, err, dat, usr, one);
      check("wrw_lat", 32'(lat), 32'd2);
      check("wrw_err", 32'(err), 32'd0);
      check("wrw_noread", 32'(rd_cnt - rd0), 32'd0);
      check("wrw_mem", mem[2], 32'hCAFE_F00D);

      do_req(1, 0, 2'b10, 0, 32'h3FFF_FFF0, 0, 32'hB, lat, err, dat, usr, one);
      check("to_lat", 32'(lat), 32'd2);
      check("to_err", 32'(err), 32'd1);
      check("to_data", dat, 32'h0);

      rd0 = rd_cnt; wr0 = wr_cnt;
      do_req(0, 1, 2'b00, 0, 32'h3FFF_FFF1, 32'h77, 32'hC, lat, err, dat, usr, one);
      check("rmwto_lat", 32'(lat), 32'd2);
      check("rmwto_err", 32'(err), 32'd1);
      check("rmwto_nowr", 32'(wr_cnt - wr0), 32'd0);

      rd0 = rd_cnt; wr0 = wr_cnt;
      do_req(1, 0, 2'b11, 0, 32'h4000_0000, 0, 32'hD, lat, err, dat, usr, one);
      check("sz3_lat", 32'(lat), 32'd1);
      check("sz3_err", 32'(err), 32'd1);
      check("sz3_user", usr, 32'hD);
      do_req(1, 1, 2'b10, 0, 32'h4000_0000, 0, 32'hE, lat, err, dat, usr, one);
      check("rw_lat", 32'(lat), 32'd1);
      check("rw_err", 32'(err), 32'd1);
      do_req(0, 0, 2'b10, 0, 32'h4000_0000, 0, 32'hF, lat, err, dat, usr, one);
      check("nop_noresp", 32'(lat), 32'd0);
      check("nop_ready", 32'(cpu_ready_o), 32'd1);
      check("illegal_nomem", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);

      // Async reset while the RMW read is outstanding.
      wr0 = wr_cnt;
      @(negedge clk);
      cpu_valid_i = 1'b1; cpu_read_i = 1'b0; cpu_write_i = 1'b1; cpu_size_i = 2'b00;
      cpu_addr_i = 32'h4000_0000; cpu_data_i = 32'h55; cpu_user_i = 32'h10;
      @(posedge clk);
      #1;
      cpu_valid_i = 1'b0; cpu_write_i = 1'b0;
      check("pre_rst_memv", 32'(mem_valid_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_memv", 32'(mem_valid_o), 32'd0);
      check("arst_memrd", 32'(mem_read_o), 32'd0);
      check("arst_maddr", mem_addr_o, 32'h0);
      check("arst_ready", 32'(cpu_ready_o), 32'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1;
         if (cpu_valid_o || mem_valid_o) seen++;
      end
      check("arst_noresp", 32'(seen), 32'd0);
      check("arst_nowr", 32'(wr_cnt - wr0), 32'd0);
      check("arst_ready_after", 32'(cpu_ready_o), 32'd1);
      check("arst_mem", mem[0], 32'hBEEF_AB44);

      do_req(1, 0, 2'b01, 0, 32'h4000_0001, 0, 32'h11, lat, err, dat, usr, one);
`ifdef MEM_RMW_BRIDGE_ALIGN_CHECK_EN
      check("mis_lat", 32'(lat), 32'd1);
      check("mis_err", 32'(err), 32'd1);
`else
      check("mis_lat", 32'(lat), 32'd2);
      check("mis_err", 32'(err), 32'd0);
      check("mis_data", dat, 32'h0000_AB44);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
